// File: rtl/plot_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : plot_arbiter_pkg
//  Brief    : Shared widths, screen geometry, state encoding and the
//             round-robin grant helper for the pixel-port arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
package plot_arbiter_pkg;

    // Pixel-port widths, also reused by the processor-side blocks
    localparam int c_XW = 8;
    localparam int c_YW = 7;
    localparam int c_CW = 3;

    // Last column/row swept by the screen clear
    localparam int c_XMAX = 159;
    localparam int c_YMAX = 119;

    // Background colour written by the clear sweep
    localparam logic [2:0] c_CLEAR_COLOR = 3'b000;

    // Arbiter state encoding
    typedef enum logic [0:0] {
        ARB   = 1'b0,
        CLEAR = 1'b1
    } arb_state_t;

    // Round-robin grant: a lone request wins outright; on contention the
    // requester that did not win last time is chosen. Result is {grant1, grant0}.
    function automatic logic [1:0] rr_grant(input logic req0,
                                            input logic req1,
                                            input logic last_grant);
        logic [1:0] grant;
        grant = 2'b00;
        if (req0 && req1) begin
            grant = last_grant ? 2'b01 : 2'b10;
        end else if (req0) begin
            grant = 2'b01;
        end else if (req1) begin
            grant = 2'b10;
        end
        return grant;
    endfunction

endpackage
`default_nettype wire

// File: rtl/plot_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : plot_arbiter_if
//  Brief    : Requester handshakes, clear control and VGA pixel-write port
//             of the plot arbiter, bundled with master/slave views.
//  Revision : 1.0 - initial release
// ============================================================================
interface plot_arbiter_if
    import plot_arbiter_pkg::*;
#(
    parameter int XW = c_XW,
    parameter int YW = c_YW,
    parameter int CW = c_CW
);

    // Screen clear control
    logic          clear_req;
    logic          clear_busy;

    // Requester 0
    logic          req0;
    logic [XW-1:0] x0;
    logic [YW-1:0] y0;
    logic [CW-1:0] c0;
    logic          ack0;

    // Requester 1
    logic          req1;
    logic [XW-1:0] x1;
    logic [YW-1:0] y1;
    logic [CW-1:0] c1;
    logic          ack1;

    // VGA adapter write port
    logic [XW-1:0] xpos;
    logic [YW-1:0] ypos;
    logic [CW-1:0] color;
    logic          plot;

    // Arbiter side
    modport slave (
        input  clear_req,
        input  req0, x0, y0, c0,
        input  req1, x1, y1, c1,
        output clear_busy, ack0, ack1,
        output xpos, ypos, color, plot
    );

    // Requester / adapter side
    modport master (
        output clear_req,
        output req0, x0, y0, c0,
        output req1, x1, y1, c1,
        input  clear_busy, ack0, ack1,
        input  xpos, ypos, color, plot
    );

endinterface
`default_nettype wire

// File: rtl/plot_arbiter_clear_sweeper.sv
`default_nettype none
// ============================================================================
//  Module   : plot_arbiter_clear_sweeper
//  Brief    : Raster counter (cx, cy) walking every pixel from (0,0) to
//             (XMAX,YMAX) one step per cycle, flagging the final pixel.
//  Revision : 1.0 - initial release
// ============================================================================
module plot_arbiter_clear_sweeper
    import plot_arbiter_pkg::*;
#(
    parameter int XW   = c_XW,
    parameter int YW   = c_YW,
    parameter int XMAX = c_XMAX,
    parameter int YMAX = c_YMAX
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          step,
    output logic [XW-1:0] cx,
    output logic [YW-1:0] cy,
    output logic          last
);

    localparam logic [XW-1:0] c_X_LAST = XW'(XMAX);
    localparam logic [YW-1:0] c_Y_LAST = YW'(YMAX);

    logic [XW-1:0] r_cx;
    logic [YW-1:0] r_cy;
    logic          w_x_wrap;
    logic          w_last;

    assign w_x_wrap = (r_cx == c_X_LAST);
    assign w_last   = w_x_wrap && (r_cy == c_Y_LAST);

    assign cx   = r_cx;
    assign cy   = r_cy;
    assign last = w_last;

    // Advance the raster position; wrap to (0,0) after the last pixel so the
    // counters never run past XMAX/YMAX.
    always_ff @(posedge clk) begin
        if (reset || start) begin
            r_cx <= '0;
            r_cy <= '0;
        end else if (step) begin
            if (w_x_wrap) begin
                r_cx <= '0;
                r_cy <= w_last ? '0 : r_cy + 1'b1;
            end else begin
                r_cx <= r_cx + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/plot_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : plot_arbiter
//  Brief    : Shares the VGA pixel-write port between two req/ack requesters
//             (round-robin on contention) and runs a full-screen clear sweep.
//  Revision : 1.0 - initial release
// ============================================================================
module plot_arbiter
    import plot_arbiter_pkg::*;
#(
    parameter int            XW          = c_XW,
    parameter int            YW          = c_YW,
    parameter int            CW          = c_CW,
    parameter int            XMAX        = c_XMAX,
    parameter int            YMAX        = c_YMAX,
    parameter logic [CW-1:0] CLEAR_COLOR = CW'(c_CLEAR_COLOR)
) (
    input  logic            clk,
    input  logic            reset,
    plot_arbiter_if.slave   bus
);

    arb_state_t    r_state;
    logic          r_last_grant;
    logic [XW-1:0] r_xpos;
    logic [YW-1:0] r_ypos;
    logic [CW-1:0] r_color;
    logic          r_plot;
    logic          r_busy;

    logic          w_arb_open;
    logic [1:0]    w_grant;
    logic          w_start;
    logic          w_step;
    logic [XW-1:0] w_cx;
    logic [YW-1:0] w_cy;
    logic          w_last;

    // Grants are only offered while arbitrating with no clear pending and no
    // reset, so nothing is acknowledged on an edge that would discard it.
    assign w_arb_open = ~reset && (r_state == ARB) && ~bus.clear_req;
    assign w_grant    = w_arb_open ? rr_grant(bus.req0, bus.req1, r_last_grant) : 2'b00;

    assign bus.ack0       = w_grant[0];
    assign bus.ack1       = w_grant[1];
    assign bus.xpos       = r_xpos;
    assign bus.ypos       = r_ypos;
    assign bus.color      = r_color;
    assign bus.plot       = r_plot;
    assign bus.clear_busy = r_busy;

    assign w_start = (r_state == ARB) && bus.clear_req;
    assign w_step  = (r_state == CLEAR);

    plot_arbiter_clear_sweeper #(
        .XW   (XW),
        .YW   (YW),
        .XMAX (XMAX),
        .YMAX (YMAX)
    ) u_sweeper (
        .clk   (clk),
        .reset (reset),
        .start (w_start),
        .step  (w_step),
        .cx    (w_cx),
        .cy    (w_cy),
        .last  (w_last)
    );

    // Arbitration / clear state machine with registered pixel-port outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ARB;
            r_last_grant <= 1'b1;
            r_xpos       <= '0;
            r_ypos       <= '0;
            r_color      <= '0;
            r_plot       <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            case (r_state)
                ARB: begin
                    if (bus.clear_req) begin
                        r_state <= CLEAR;
                        r_busy  <= 1'b1;
                        r_plot  <= 1'b0;
                    end else if (w_grant[0]) begin
                        r_xpos       <= bus.x0;
                        r_ypos       <= bus.y0;
                        r_color      <= bus.c0;
                        r_plot       <= 1'b1;
                        r_last_grant <= 1'b0;
                    end else if (w_grant[1]) begin
                        r_xpos       <= bus.x1;
                        r_ypos       <= bus.y1;
                        r_color      <= bus.c1;
                        r_plot       <= 1'b1;
                        r_last_grant <= 1'b1;
                    end else begin
                        r_plot <= 1'b0;
                    end
                end
                CLEAR: begin
                    // clear_req is ignored here; the sweep always runs to the end
                    r_xpos  <= w_cx;
                    r_ypos  <= w_cy;
                    r_color <= CLEAR_COLOR;
                    r_plot  <= 1'b1;
                    if (w_last) begin
                        r_state <= ARB;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ARB;
                    r_busy  <= 1'b0;
                    r_plot  <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_plot_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_plot_arbiter
//  Brief    : Self-checking bench for plot_arbiter: directed handshakes,
//             round-robin contention, random traffic against a behavioural
//             model, full clear sweeps, re-issued clear and reset mid-sweep.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_plot_arbiter;

    localparam int XW   = 8;
    localparam int YW   = 7;
    localparam int CW   = 3;
    localparam int XMAX = 159;
    localparam int YMAX = 119;
    localparam int NPIX = (XMAX + 1) * (YMAX + 1);

    logic clk = 1'b0;
    logic reset;

    plot_arbiter_if #(.XW(XW), .YW(YW), .CW(CW)) bus ();

    plot_arbiter #(
        .XW          (XW),
        .YW          (YW),
        .CW          (CW),
        .XMAX        (XMAX),
        .YMAX        (YMAX),
        .CLEAR_COLOR (3'b000)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // 10-time-unit clock
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Behavioural model: who won last, and what the pixel port should show
    int m_last;
    bit m_plot;
    int m_x, m_y, m_c;

    int g;
    bit ab;
    bit p0, p1;

    // Pack a pixel as {x[7:0], y[6:0], c[2:0]}
    function automatic logic [31:0] pk(input int x, input int y, input int c);
        return 32'({x[7:0], y[6:0], c[2:0]});
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One arbitration cycle: inputs are already driven; check acks against
    // the model's decision and the port against the model's previous pixel.
    task automatic cycle(output int gnt);
        #1;
        gnt = -1;
        if (!reset && !bus.clear_req) begin
            if (bus.req0 && bus.req1) gnt = (m_last == 0) ? 1 : 0;
            else if (bus.req0)        gnt = 0;
            else if (bus.req1)        gnt = 1;
        end
        check("ack0", 32'(bus.ack0), 32'(gnt == 0));
        check("ack1", 32'(bus.ack1), 32'(gnt == 1));
        check("plot", 32'(bus.plot), 32'(m_plot));
        if (m_plot) begin
            check("pixel", pk(int'(bus.xpos), int'(bus.ypos), int'(bus.color)), pk(m_x, m_y, m_c));
        end
        check("clear_busy_idle", 32'(bus.clear_busy), 32'(0));
        if (reset) begin
            m_plot = 1'b0;
            m_last = 1;
        end else if (gnt == 0) begin
            m_plot = 1'b1; m_x = int'(bus.x0); m_y = int'(bus.y0); m_c = int'(bus.c0); m_last = 0;
        end else if (gnt == 1) begin
            m_plot = 1'b1; m_x = int'(bus.x1); m_y = int'(bus.y1); m_c = int'(bus.c1); m_last = 1;
        end else begin
            m_plot = 1'b0;
        end
        @(posedge clk); #1;
    endtask

    // Pulse clear_req and follow the sweep. Optionally re-pulse clear_req at
    // cycle reissue_at, or stop following once abort_at pixels have been seen.
    task automatic do_clear(input int abort_at, input int reissue_at, output bit aborted);
        int busy_cnt, plot_cnt, bad, ackbad, k;
        bit done;
        logic [31:0] got, first_px, px160, last_px;
        busy_cnt = 0; plot_cnt = 0; bad = 0; ackbad = 0; done = 1'b0; aborted = 1'b0;
        first_px = '1; px160 = '1; last_px = '1;
        bus.clear_req = 1'b1;
        #1;
        check("clr_req_ack0", 32'(bus.ack0), 32'(0));
        check("clr_req_ack1", 32'(bus.ack1), 32'(0));
        check("clr_req_plot", 32'(bus.plot), 32'(m_plot));
        @(posedge clk); #1;
        bus.clear_req = 1'b0;
        for (int n = 0; n < NPIX + 50; n++) begin
            if (bus.clear_busy === 1'b1) begin
                busy_cnt++;
                if (bus.ack0 !== 1'b0 || bus.ack1 !== 1'b0) ackbad++;
            end
            if (bus.plot === 1'b1) begin
                k   = plot_cnt;
                got = pk(int'(bus.xpos), int'(bus.ypos), int'(bus.color));
                if (got !== pk(k % (XMAX + 1), k / (XMAX + 1), 0)) bad++;
                if (k == 0)        first_px = got;
                if (k == XMAX + 1) px160    = got;
                if (k == NPIX - 1) last_px  = got;
                plot_cnt++;
            end
            if (bus.clear_busy !== 1'b1) begin
                done = 1'b1;
                break;
            end
            if (abort_at >= 0 && plot_cnt == abort_at) begin
                aborted = 1'b1;
                break;
            end
            bus.clear_req = (n == reissue_at);
            @(posedge clk); #1;
        end
        bus.clear_req = 1'b0;
        check("clr_pixels_in_order", 32'(bad), 32'(0));
        check("clr_first_px", first_px, pk(0, 0, 0));
        if (aborted) begin
            check("clr_abort_point", 32'(plot_cnt), 32'(abort_at));
        end else begin
            check("clr_done", 32'(done), 32'(1));
            check("clr_busy_cycles", 32'(busy_cnt), 32'(NPIX));
            check("clr_plot_pulses", 32'(plot_cnt), 32'(NPIX));
            check("clr_no_ack", 32'(ackbad), 32'(0));
            check("clr_px161", px160, pk(0, 1, 0));
            check("clr_last_px", last_px, pk(XMAX, YMAX, 0));
            // Port still shows the last swept pixel on the first ARB cycle
            m_plot = 1'b1; m_x = XMAX; m_y = YMAX; m_c = 0;
        end
    endtask

    initial begin
        reset = 1'b1;
        bus.clear_req = 1'b0;
        bus.req0 = 1'b1; bus.x0 = 8'd33; bus.y0 = 7'd44; bus.c0 = 3'd6;
        bus.req1 = 1'b0; bus.x1 = '0;    bus.y1 = '0;    bus.c1 = '0;
        m_last = 1; m_plot = 1'b0; m_x = 0; m_y = 0; m_c = 0;
        @(posedge clk); #1;
        check("reset_xpos", 32'(bus.xpos), 32'(0));

        // Reset held with req0 high: no ack, no plot, not busy
        repeat (3) cycle(g);
        reset = 1'b0;
        cycle(g);                      // ack0 on the first cycle after release
        check("first_grant", 32'(g), 32'(0));

        // Lone requester 1 for one cycle, x0 pixel appears meanwhile
        bus.req0 = 1'b0;
        bus.req1 = 1'b1; bus.x1 = 8'd10; bus.y1 = 7'd20; bus.c1 = 3'b101;
        cycle(g);
        bus.req1 = 1'b0;
        cycle(g);                      // (10,20,5) with plot=1
        cycle(g);                      // plot falls

        // Continuous contention straight after reset: 0,1,0,1,0,1
        reset = 1'b1;
        cycle(g);
        cycle(g);
        reset = 1'b0;
        bus.req0 = 1'b1; bus.req1 = 1'b1;
        for (int i = 0; i < 6; i++) begin
            bus.x0 = 8'(i * 7 + 1);  bus.y0 = 7'(i + 2);  bus.c0 = 3'(i);
            bus.x1 = 8'(200 - i);    bus.y1 = 7'(100 + i); bus.c1 = 3'(7 - i);
            cycle(g);
            check("alt_grant", 32'(g), 32'(i % 2));
        end
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        cycle(g);
        cycle(g);

        // Random traffic, data held stable until acknowledged
        p0 = 1'b0; p1 = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (!p0) begin
                bus.req0 = 1'($urandom_range(0, 1));
                bus.x0 = XW'($urandom); bus.y0 = YW'($urandom); bus.c0 = CW'($urandom);
                p0 = bus.req0;
            end
            if (!p1) begin
                bus.req1 = 1'($urandom_range(0, 1));
                bus.x1 = XW'($urandom); bus.y1 = YW'($urandom); bus.c1 = CW'($urandom);
                p1 = bus.req1;
            end
            cycle(g);
            if (g == 0) p0 = 1'b0;
            if (g == 1) p1 = 1'b0;
        end
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        cycle(g);
        cycle(g);

        // Plain clear from idle
        do_clear(-1, -1, ab);
        cycle(g);
        cycle(g);

        // Clear issued alongside a held req0, plus a second clear_req mid-sweep
        bus.req0 = 1'b1; bus.x0 = 8'd250; bus.y0 = 7'd127; bus.c0 = 3'd7;
        do_clear(-1, 5000, ab);
        cycle(g);
        check("post_clear_grant", 32'(g), 32'(0));
        bus.req0 = 1'b0;
        cycle(g);
        cycle(g);

        // Reset mid-sweep aborts at once, then a new clear restarts at (0,0)
        do_clear(500, -1, ab);
        check("abort_taken", 32'(ab), 32'(1));
        reset = 1'b1;
        @(posedge clk); #1;
        check("abort_plot", 32'(bus.plot), 32'(0));
        check("abort_busy", 32'(bus.clear_busy), 32'(0));
        m_plot = 1'b0; m_last = 1;
        reset = 1'b0;
        do_clear(-1, -1, ab);
        cycle(g);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
